// File: rtl/tl_probe_multicast_if.sv
// Signal bundle for the probe multicast engine: directory request, B probe channel,
// C response channel and merged completion. master = engine side, slave = environment.
interface tl_probe_multicast_if #(
    parameter int N_CLIENTS = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int SOURCE_W  = 4
);
    localparam int CID_W      = N_CLIENTS > 1 ? $clog2(N_CLIENTS) : 1;
    localparam int M_SOURCE_W = SOURCE_W + CID_W;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [N_CLIENTS-1:0]  req_mask_i;
    logic [2:0]            req_param_i;
    logic [SOURCE_W-1:0]   req_source_i;
    logic [ADDR_W-1:0]     req_address_i;

    logic                  b_valid_o;
    logic                  b_ready_i;
    logic [2:0]            b_opcode_o;
    logic [2:0]            b_param_o;
    logic [3:0]            b_size_o;
    logic [SOURCE_W-1:0]   b_source_o;
    logic [ADDR_W-1:0]     b_address_o;
    logic [7:0]            b_mask_o;
    logic [DATA_W-1:0]     b_data_o;
    logic                  b_corrupt_o;
    logic [CID_W-1:0]      b_dest_o;

    logic                  c_valid_i;
    logic                  c_ready_o;
    logic [2:0]            c_opcode_i;
    logic [2:0]            c_param_i;
    logic [M_SOURCE_W-1:0] c_source_i;
    logic [DATA_W-1:0]     c_data_i;
    logic                  c_corrupt_i;

    logic                  done_valid_o;
    logic                  done_ready_i;
    logic                  done_dirty_o;
    logic [DATA_W-1:0]     done_data_o;
    logic                  done_corrupt_o;
    logic                  done_error_o;

    modport master (
        input  req_valid_i, req_mask_i, req_param_i, req_source_i, req_address_i,
        output req_ready_o,
        output b_valid_o, b_opcode_o, b_param_o, b_size_o, b_source_o, b_address_o,
        output b_mask_o, b_data_o, b_corrupt_o, b_dest_o,
        input  b_ready_i,
        input  c_valid_i, c_opcode_i, c_param_i, c_source_i, c_data_i, c_corrupt_i,
        output c_ready_o,
        output done_valid_o, done_dirty_o, done_data_o, done_corrupt_o, done_error_o,
        input  done_ready_i
    );

    modport slave (
        output req_valid_i, req_mask_i, req_param_i, req_source_i, req_address_i,
        input  req_ready_o,
        input  b_valid_o, b_opcode_o, b_param_o, b_size_o, b_source_o, b_address_o,
        input  b_mask_o, b_data_o, b_corrupt_o, b_dest_o,
        output b_ready_i,
        output c_valid_i, c_opcode_i, c_param_i, c_source_i, c_data_i, c_corrupt_i,
        input  c_ready_o,
        input  done_valid_o, done_dirty_o, done_data_o, done_corrupt_o, done_error_o,
        output done_ready_i
    );
endinterface

// File: rtl/tl_probe_multicast.sv
// Manager-side probe engine: fans one directory request out as directed Probes on B,
// collects one ProbeAck/ProbeAckData per probed client on C, returns a merged completion.
module tl_probe_multicast #(
    parameter int N_CLIENTS = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int SOURCE_W  = 4
) (
    input logic                  clk,
    input logic                  rst,
    tl_probe_multicast_if.master bus
);
    localparam int CID_W      = N_CLIENTS > 1 ? $clog2(N_CLIENTS) : 1;
    localparam int M_SOURCE_W = SOURCE_W + CID_W;

    localparam logic [2:0] OP_PROBE    = 3'd6;
    localparam logic [2:0] OP_ACK      = 3'd4;
    localparam logic [2:0] OP_ACK_DATA = 3'd5;
    localparam logic [3:0] PROBE_SIZE  = 4'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [N_CLIENTS-1:0] issue_mask_q, issue_mask_d;
    logic [N_CLIENTS-1:0] outst_mask_q, outst_mask_d;
    logic [2:0]           param_q, param_d;
    logic [SOURCE_W-1:0]  source_q, source_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 dirty_q, dirty_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 corrupt_q, corrupt_d;
    logic                 error_q, error_d;

    logic [CID_W-1:0]     dest_c;
    logic [CID_W-1:0]     cid_c;
    logic                 unused_c;

    assign cid_c    = bus.c_source_i[M_SOURCE_W-1:SOURCE_W];
    assign unused_c = ^{bus.c_param_i, bus.c_source_i[SOURCE_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_mask_q <= '0;
            outst_mask_q <= '0;
            param_q      <= '0;
            source_q     <= '0;
            addr_q       <= '0;
            dirty_q      <= 1'b0;
            data_q       <= '0;
            corrupt_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_mask_q <= issue_mask_d;
            outst_mask_q <= outst_mask_d;
            param_q      <= param_d;
            source_q     <= source_d;
            addr_q       <= addr_d;
            dirty_q      <= dirty_d;
            data_q       <= data_d;
            corrupt_q    <= corrupt_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        issue_mask_d = issue_mask_q;
        outst_mask_d = outst_mask_q;
        param_d      = param_q;
        source_d     = source_q;
        addr_d       = addr_q;
        dirty_d      = dirty_q;
        data_d       = data_q;
        corrupt_d    = corrupt_q;
        error_d      = error_q;

        // Lowest set bit wins, so probes go out in ascending client order.
        dest_c = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (issue_mask_q[i]) dest_c = CID_W'(i);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    issue_mask_d = bus.req_mask_i;
                    outst_mask_d = '0;
                    param_d      = bus.req_param_i;
                    source_d     = bus.req_source_i;
                    addr_d       = bus.req_address_i;
                    dirty_d      = 1'b0;
                    data_d       = '0;
                    corrupt_d    = 1'b0;
                    error_d      = 1'b0;
                    state_d      = (bus.req_mask_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (state_q == ISSUE && bus.b_ready_i) begin
                    issue_mask_d[dest_c] = 1'b0;
                    outst_mask_d[dest_c] = 1'b1;
                end
                // Ack check uses the pre-issue mask: an ack for the probe issued this cycle is unexpected.
                if (bus.c_valid_i) begin
                    if ((bus.c_opcode_i == OP_ACK || bus.c_opcode_i == OP_ACK_DATA) &&
                        32'(cid_c) < N_CLIENTS && outst_mask_q[cid_c]) begin
                        outst_mask_d[cid_c] = 1'b0;
                        if (bus.c_opcode_i == OP_ACK_DATA) begin
                            dirty_d   = 1'b1;
                            corrupt_d = corrupt_q | bus.c_corrupt_i;
                            if (!dirty_q) data_d = bus.c_data_i;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
                if (issue_mask_d == '0) state_d = (outst_mask_d == '0) ? DONE : WAIT;
            end
            DONE: begin
                if (bus.done_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready_o    = (state_q == IDLE);
    assign bus.b_valid_o      = (state_q == ISSUE);
    assign bus.b_opcode_o     = OP_PROBE;
    assign bus.b_param_o      = param_q;
    assign bus.b_size_o       = PROBE_SIZE;
    assign bus.b_source_o     = source_q;
    assign bus.b_address_o    = addr_q;
    assign bus.b_mask_o       = 8'hFF;
    assign bus.b_data_o       = '0;
    assign bus.b_corrupt_o    = 1'b0;
    assign bus.b_dest_o       = dest_c;
    assign bus.c_ready_o      = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.done_valid_o   = (state_q == DONE);
    assign bus.done_dirty_o   = dirty_q;
    assign bus.done_data_o    = data_q;
    assign bus.done_corrupt_o = corrupt_q;
    assign bus.done_error_o   = error_q;
endmodule

// File: tb/tb_tl_probe_multicast.sv
// Self-checking bench for tl_probe_multicast: B probes and completions are checked
// against expectations queued when each request or response is driven.
module tb_tl_probe_multicast;
    localparam int N_CLIENTS = 4;
    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 64;
    localparam int SOURCE_W  = 4;

    typedef struct {
        logic [1:0]  dest;
        logic [2:0]  param;
        logic [3:0]  source;
        logic [63:0] addr;
    } exp_b_t;

    typedef struct {
        logic        dirty;
        logic [63:0] data;
        logic        corrupt;
        logic        error;
    } exp_done_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    exp_b_t    exp_b[$];
    exp_done_t exp_done[$];

    tl_probe_multicast_if #(
        .N_CLIENTS(N_CLIENTS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W)
    ) bus ();

    tl_probe_multicast #(
        .N_CLIENTS(N_CLIENTS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic monitor();
        exp_b_t    eb;
        exp_done_t ed;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.b_valid_o && bus.b_ready_i) begin
                checks++;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL b_unexpected: probe to dest=%0d with nothing expected", bus.b_dest_o);
                end else begin
                    eb = exp_b.pop_front();
                    if (bus.b_dest_o !== eb.dest || bus.b_opcode_o !== 3'd6 || bus.b_param_o !== eb.param ||
                        bus.b_source_o !== eb.source || bus.b_address_o !== eb.addr || bus.b_size_o !== 4'd3 ||
                        bus.b_mask_o !== 8'hFF || bus.b_data_o !== 64'h0 || bus.b_corrupt_o !== 1'b0) begin
                        failures++;
                        $display("FAIL b_probe: got dest=%0d op=%0d param=%0d src=%0h addr=%0h size=%0d mask=%0h, want dest=%0d op=6 param=%0d src=%0h addr=%0h size=3 mask=ff",
                                 bus.b_dest_o, bus.b_opcode_o, bus.b_param_o, bus.b_source_o, bus.b_address_o,
                                 bus.b_size_o, bus.b_mask_o, eb.dest, eb.param, eb.source, eb.addr);
                    end
                end
            end
            if (!rst && bus.done_valid_o && bus.done_ready_i) begin
                checks++;
                if (exp_done.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: completion with nothing expected");
                end else begin
                    ed = exp_done.pop_front();
                    if (bus.done_dirty_o !== ed.dirty || bus.done_corrupt_o !== ed.corrupt ||
                        bus.done_error_o !== ed.error || (ed.dirty && bus.done_data_o !== ed.data)) begin
                        failures++;
                        $display("FAIL done_result: got dirty=%0b data=%0h corrupt=%0b error=%0b, want dirty=%0b data=%0h corrupt=%0b error=%0b",
                                 bus.done_dirty_o, bus.done_data_o, bus.done_corrupt_o, bus.done_error_o,
                                 ed.dirty, ed.data, ed.corrupt, ed.error);
                    end
                end
            end
        end
    endtask

    // Returns at the falling edge right after the request was accepted.
    task automatic send_req(input logic [3:0] mask, input logic [2:0] param,
                            input logic [3:0] source, input logic [63:0] addr);
        int n;
        @(negedge clk);
        bus.req_valid_i   = 1'b1;
        bus.req_mask_i    = mask;
        bus.req_param_i   = param;
        bus.req_source_i  = source;
        bus.req_address_i = addr;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (mask[i]) exp_b.push_back('{dest: 2'(i), param: param, source: source, addr: addr});
        end
        n = 0;
        while (!bus.req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            failures++;
            $display("FAIL req_timeout: req_ready_o=%0b, want 1", bus.req_ready_o);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    // Returns at the falling edge right after the response was accepted.
    task automatic send_ack(input logic [1:0] cid, input logic [2:0] op,
                            input logic [63:0] data, input logic corrupt);
        int n;
        bus.c_valid_i   = 1'b1;
        bus.c_opcode_i  = op;
        bus.c_param_i   = 3'd1;
        bus.c_source_i  = {cid, 4'h5};
        bus.c_data_i    = data;
        bus.c_corrupt_i = corrupt;
        n = 0;
        while (!bus.c_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            failures++;
            $display("FAIL c_timeout: c_ready_o=%0b, want 1", bus.c_ready_o);
        end
        @(negedge clk);
        bus.c_valid_i   = 1'b0;
        bus.c_corrupt_i = 1'b0;
    endtask

    task automatic finish_done();
        #1;
        checks++;
        if (bus.done_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL done_rise: done_valid_o=%0b, want 1", bus.done_valid_o);
        end
        bus.done_ready_i = 1'b1;
        @(negedge clk);
        bus.done_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.done_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL done_return: done_valid_o=%0b req_ready_o=%0b, want 0 1", bus.done_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b1 || bus.b_valid_o !== 1'b0 || bus.c_ready_o !== 1'b0 ||
            bus.done_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: req_ready=%0b b_valid=%0b c_ready=%0b done_valid=%0b, want 1 0 0 0",
                     bus.req_ready_o, bus.b_valid_o, bus.c_ready_o, bus.done_valid_o);
        end
        checks++;
        if (bus.done_dirty_o !== 1'b0 || bus.done_data_o !== 64'h0 || bus.done_corrupt_o !== 1'b0 ||
            bus.done_error_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_done_fields: dirty=%0b data=%0h corrupt=%0b error=%0b, want all 0",
                     bus.done_dirty_o, bus.done_data_o, bus.done_corrupt_o, bus.done_error_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bus.b_ready_i = 1'b1;
        exp_done.push_back('{dirty: 1'b0, data: 64'h0, corrupt: 1'b0, error: 1'b0});
        send_req(4'b1010, 3'd2, 4'hA, 64'h0000_1000_0000_0040);
        #1;
        checks++;
        if (bus.b_valid_o !== 1'b1 || bus.b_dest_o !== 2'd1) begin
            failures++;
            $display("FAIL basic_first_probe: b_valid=%0b dest=%0d, want 1 1", bus.b_valid_o, bus.b_dest_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.b_valid_o !== 1'b1 || bus.b_dest_o !== 2'd3) begin
            failures++;
            $display("FAIL basic_second_probe: b_valid=%0b dest=%0d, want 1 3", bus.b_valid_o, bus.b_dest_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.b_valid_o !== 1'b0 || bus.c_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_wait: b_valid=%0b c_ready=%0b, want 0 1", bus.b_valid_o, bus.c_ready_o);
        end
        @(negedge clk);
        send_ack(2'd1, 3'd4, 64'h0, 1'b0);
        #1;
        checks++;
        if (bus.done_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_done: done_valid_o=%0b, want 0", bus.done_valid_o);
        end
        send_ack(2'd3, 3'd4, 64'h0, 1'b0);
        finish_done();
    endtask

    task automatic test_dirty();
        exp_done.push_back('{dirty: 1'b1, data: 64'hDEAD_BEEF, corrupt: 1'b1, error: 1'b0});
        send_req(4'b0001, 3'd0, 4'h3, 64'h0000_0000_0000_2000);
        @(negedge clk);
        send_ack(2'd0, 3'd5, 64'hDEAD_BEEF, 1'b1);
        finish_done();
    endtask

    task automatic test_first_data();
        exp_done.push_back('{dirty: 1'b1, data: 64'h1111_2222_3333_4444, corrupt: 1'b0, error: 1'b0});
        send_req(4'b0110, 3'd1, 4'h7, 64'h0000_0000_ABCD_0080);
        @(negedge clk);
        send_ack(2'd1, 3'd5, 64'h1111_2222_3333_4444, 1'b0);
        send_ack(2'd2, 3'd5, 64'h5555_6666_7777_8888, 1'b0);
        finish_done();
    endtask

    task automatic test_zero_mask();
        exp_done.push_back('{dirty: 1'b0, data: 64'h0, corrupt: 1'b0, error: 1'b0});
        send_req(4'b0000, 3'd2, 4'h1, 64'h0000_0000_0000_3000);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.done_valid_o !== 1'b1 || bus.b_valid_o !== 1'b0 || bus.done_dirty_o !== 1'b0 ||
                bus.done_error_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL zero_hold%0d: done_valid=%0b b_valid=%0b dirty=%0b error=%0b req_ready=%0b, want 1 0 0 0 0",
                         k, bus.done_valid_o, bus.b_valid_o, bus.done_dirty_o, bus.done_error_o, bus.req_ready_o);
            end
            @(negedge clk);
        end
        finish_done();
    endtask

    task automatic test_stall();
        bus.b_ready_i = 1'b0;
        exp_done.push_back('{dirty: 1'b0, data: 64'h0, corrupt: 1'b0, error: 1'b0});
        send_req(4'b1111, 3'd1, 4'h9, 64'h0000_0000_0000_4040);
        for (int s = 0; s < 4; s++) begin
            bus.b_ready_i = 1'b0;
            #1;
            checks++;
            if (bus.b_valid_o !== 1'b1 || bus.b_dest_o !== 2'(s)) begin
                failures++;
                $display("FAIL stall_dest%0d: b_valid=%0b dest=%0d, want 1 %0d", s, bus.b_valid_o, bus.b_dest_o, s);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.b_valid_o !== 1'b1 || bus.b_dest_o !== 2'(s)) begin
                failures++;
                $display("FAIL stall_hold%0d: b_valid=%0b dest=%0d, want 1 %0d", s, bus.b_valid_o, bus.b_dest_o, s);
            end
            bus.b_ready_i = 1'b1;
            if (s == 2) begin
                bus.c_valid_i  = 1'b1;
                bus.c_opcode_i = 3'd4;
                bus.c_source_i = {2'd0, 4'h5};
            end
            @(negedge clk);
            bus.c_valid_i = 1'b0;
        end
        #1;
        checks++;
        if (bus.b_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_wait: b_valid=%0b, want 0", bus.b_valid_o);
        end
        send_ack(2'd3, 3'd4, 64'h0, 1'b0);
        send_ack(2'd1, 3'd4, 64'h0, 1'b0);
        #1;
        checks++;
        if (bus.done_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_early_done: done_valid_o=%0b, want 0", bus.done_valid_o);
        end
        send_ack(2'd2, 3'd4, 64'h0, 1'b0);
        finish_done();
    endtask

    task automatic test_error_reset();
        exp_done.push_back('{dirty: 1'b0, data: 64'h0, corrupt: 1'b0, error: 1'b1});
        send_req(4'b0001, 3'd0, 4'h2, 64'h0000_0000_0000_5000);
        @(negedge clk);
        send_ack(2'd2, 3'd4, 64'h0, 1'b0);
        #1;
        checks++;
        if (bus.done_valid_o !== 1'b0 || bus.c_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL error_stray: done_valid=%0b c_ready=%0b, want 0 1", bus.done_valid_o, bus.c_ready_o);
        end
        send_ack(2'd0, 3'd4, 64'h0, 1'b0);
        finish_done();

        send_req(4'b0001, 3'd0, 4'h2, 64'h0000_0000_0000_6000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b1 || bus.b_valid_o !== 1'b0 || bus.c_ready_o !== 1'b0 ||
            bus.done_valid_o !== 1'b0 || bus.done_error_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_wait: req_ready=%0b b_valid=%0b c_ready=%0b done_valid=%0b error=%0b, want 1 0 0 0 0",
                     bus.req_ready_o, bus.b_valid_o, bus.c_ready_o, bus.done_valid_o, bus.done_error_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.done_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL reset_stale%0d: done_valid=%0b req_ready=%0b, want 0 1", k, bus.done_valid_o, bus.req_ready_o);
            end
        end
        exp_done.push_back('{dirty: 1'b1, data: 64'h0123_4567_89AB_CDEF, corrupt: 1'b0, error: 1'b0});
        send_req(4'b0100, 3'd2, 4'hC, 64'h0000_0000_0000_7000);
        @(negedge clk);
        send_ack(2'd2, 3'd5, 64'h0123_4567_89AB_CDEF, 1'b0);
        finish_done();
    endtask

    initial begin
        rst               = 1'b1;
        bus.req_valid_i   = 1'b0;
        bus.req_mask_i    = '0;
        bus.req_param_i   = '0;
        bus.req_source_i  = '0;
        bus.req_address_i = '0;
        bus.b_ready_i     = 1'b0;
        bus.c_valid_i     = 1'b0;
        bus.c_opcode_i    = '0;
        bus.c_param_i     = '0;
        bus.c_source_i    = '0;
        bus.c_data_i      = '0;
        bus.c_corrupt_i   = 1'b0;
        bus.done_ready_i  = 1'b0;
        fork
            monitor();
        join_none

        test_reset();
        test_basic();
        test_dirty();
        test_first_data();
        test_zero_mask();
        test_stall();
        test_error_reset();

        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (exp_b.size() != 0 || exp_done.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending probes=%0d completions=%0d, want 0 0", exp_b.size(), exp_done.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tl_probe_multicast.md
# tl_probe_multicast

Manager-side probe engine that drives the B channel into the client socket and consumes the resulting ProbeAck/ProbeAckData on the C channel. It takes one probe request from the L2 directory with a sharer bitmask, issues one directed Probe per set bit, and collects one acknowledgement per probed client. When all acknowledgements have arrived it returns a single completion carrying the merged result.

## Interface
- N_CLIENTS, 4, number of clients behind the socket; CID_W = N_CLIENTS>1 ? $clog2(N_CLIENTS) : 1
- DATA_W, 64, data width; probe size is $clog2(DATA_W/8)
- ADDR_W, 64, address width
- SOURCE_W, 4, client source width; M_SOURCE_W = SOURCE_W + CID_W
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid_i / req_ready_o  in/out  1  probe request handshake
- req_mask_i  input  N_CLIENTS  clients to probe, bit i = client i
- req_param_i  input  3  probe cap (toN/toB/toT)
- req_source_i  input  SOURCE_W  L2 source ID placed on b_source_o
- req_address_i  input  ADDR_W  line address
- b_valid_o / b_ready_i  out/in  1  B channel handshake
- b_opcode_o 3, b_param_o 3, b_size_o 4, b_source_o SOURCE_W, b_address_o ADDR_W, b_mask_o 8, b_data_o DATA_W, b_corrupt_o 1  outputs  B payload
- b_dest_o  output  CID_W  destination client ID
- c_valid_i / c_ready_o  in/out  1  C channel handshake (probe responses only)
- c_opcode_i 3, c_param_i 3, c_source_i M_SOURCE_W, c_data_i DATA_W, c_corrupt_i 1  inputs  C payload; client ID = c_source_i[M_SOURCE_W-1:SOURCE_W]
- done_valid_o / done_ready_i  out/in  1  completion handshake
- done_dirty_o  output  1  at least one ProbeAckData received
- done_data_o  output  DATA_W  data of the first ProbeAckData
- done_corrupt_o  output  1  OR of c_corrupt_i over accepted ProbeAckData
- done_error_o  output  1  unexpected response seen during this transaction

## Operation
- FSM states IDLE, ISSUE, WAIT, DONE. Registers: issue_mask, outst_mask, latched param/source/address, dirty, data, corrupt, error.
- IDLE: req_ready_o=1. On req handshake, latch the request, set issue_mask=req_mask_i, outst_mask=0, and clear dirty/corrupt/error. If req_mask_i==0, go to DONE; otherwise go to ISSUE.
- ISSUE: b_valid_o=1 and b_dest_o = index of the lowest set bit of issue_mask.
  - Fixed B payload: b_opcode_o=6 (Probe), b_param_o=latched param, b_size_o=$clog2(DATA_W/8), b_mask_o=8'hFF, b_data_o=0, b_corrupt_o=0.
  - On b handshake, clear that bit in issue_mask and set it in outst_mask.
  - When the last bit is issued, go to WAIT.
- ISSUE and WAIT: c_ready_o=1. On c handshake with client k:
  - Opcode 4 (ProbeAck) or 5 (ProbeAckData) and outst_mask[k]=1: clear outst_mask[k].
  - Opcode 5: set dirty. Capture c_data_i only if dirty was 0. OR c_corrupt_i into corrupt.
  - Any other opcode, or outst_mask[k]=0: accept, drop, set error.
- Same-cycle B issue and C ack are both applied; the issue sets and the ack clears distinct bits.
- Leave for DONE when issue_mask==0 and outst_mask==0, evaluated on the post-update state.
- DONE: done_valid_o=1 with done_* held stable. On done_ready_i go to IDLE.
- Outputs that are not valid carry the latched values; no X.

## Timing
- Reset: state=IDLE and all masks and flags cleared. After the first edge with rst=1: req_ready_o=1, b_valid_o=0, c_ready_o=0, done_valid_o=0, done_* = 0.
- rst during any state abandons the transaction. Outstanding probes are forgotten and the next cycle is IDLE.
- b_valid_o rises the cycle after req acceptance. With b_ready_i held at 1, one probe issues per cycle.
- done_valid_o rises the cycle after the final ack is accepted.
- With req_mask_i==0, done_valid_o rises the cycle after req acceptance.
- b_valid_o is never dropped without a handshake, and b_dest_o/payload stay stable while b_ready_i=0.
- req_ready_o=0 outside IDLE. There is no request overlap, so back-to-back transactions have a minimum turnaround of one DONE cycle plus one IDLE cycle.

## Test plan
- Mask 4'b1010, b_ready_i=1, ProbeAck from clients 1 and 3 after 2 cycles -> probes issued to dest 1 then 3 on consecutive cycles with opcode 6; done_valid_o one cycle after the second ack; dirty=0, error=0.
- Mask 4'b0001, ProbeAckData data=64'hDEAD_BEEF, corrupt=1 -> done_dirty_o=1, done_data_o=64'hDEAD_BEEF, done_corrupt_o=1.
- Mask 4'b0110, both clients answer ProbeAckData (data A then B) -> done_data_o=A and dirty=1.
- Mask 4'b0000 -> no b_valid_o; done_valid_o the cycle after acceptance; done_ready_i=0 holds it for 3 cycles, then one ready cycle returns to IDLE.
- b_ready_i toggled 0/1 with mask 4'b1111 -> b_dest_o is stable during stalls; order is 0,1,2,3. An ack from client 0 during issue of client 2 is applied in the same cycle.
- ProbeAck from an unprobed client 2 with mask 4'b0001, then rst asserted in WAIT -> done_error_o=1 once client 0 acks. In the reset run, IDLE and req_ready_o=1 follow the reset edge and no stale done appears.
